// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter (inhibit, request-to-send, device-clocked shift, ACK check)
//   clk, reset                : system clock, asynchronous active-high reset
//   tx_valid, tx_data, tx_ready: command byte handshake (accepted only in IDLE)
//   tx_done, tx_err           : one-cycle result pulses (ACK received / timeout or NACK)
//   rx_inhibit                : high while busy so the receive side ignores the bus
//   ps2_clk_i, ps2_data_i     : asynchronous pad inputs
//   ps2_clk_oe, ps2_data_oe   : open-drain pull-down enables (1 = drive low)
//   Optional macro PS2_TX_RESEND_EN: retry a failed frame up to twice before reporting tx_err.
module ps2_host_tx #(
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int INHIBIT_CYCLES = CLK_FREQ_HZ / 10_000,
    parameter int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1_000 * 15,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       rx_inhibit,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [IW-1:0] INH_MAX  = IW'(INHIBIT_CYCLES);
    localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT_CYCLES);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK, WAITREL, ERR} state_t;
    state_t state, state_n, nxt;

    logic [1:0]    clk_sync, data_sync;
    logic [FW-1:0] clk_cnt, data_cnt;
    logic          clk_f, data_f, clk_f_q, fall;
    logic [IW-1:0] inh_cnt;
    logic [WW-1:0] wd_cnt;
    logic [3:0]    n;
    logic [8:0]    shift, frm;
    logic          data_oe_q, watch, timeout, fail, retry_ok;

    // A line's filtered level follows the synchronised level only after FILTER_LEN consecutive differing cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_f     <= 1'b1;
            data_f    <= 1'b1;
            clk_f_q   <= 1'b1;
            clk_cnt   <= '0;
            data_cnt  <= '0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_i};
            data_sync <= {data_sync[0], ps2_data_i};
            clk_f_q   <= clk_f;
            clk_cnt   <= clk_sync[1] == clk_f || clk_cnt == FLT_LAST ? '0 : clk_cnt + 1'b1;
            data_cnt  <= data_sync[1] == data_f || data_cnt == FLT_LAST ? '0 : data_cnt + 1'b1;
            if (clk_sync[1] != clk_f && clk_cnt == FLT_LAST) clk_f <= clk_sync[1];
            if (data_sync[1] != data_f && data_cnt == FLT_LAST) data_f <= data_sync[1];
        end
    end

    assign fall    = clk_f_q & ~clk_f;
    assign watch   = state == RTS || state == SHIFT || state == ACK || state == WAITREL;
    // A fall in the same cycle as expiry counts as progress, not as a timeout.
    assign timeout = watch && wd_cnt == WD_MAX && !fall;

`ifdef PS2_TX_RESEND_EN
    logic [1:0] retries;
    assign retry_ok = retries != 2'd2;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) retries <= '0;
        else if (state == IDLE) retries <= '0;
        else if (fail && retry_ok) retries <= retries + 1'b1;
    end
`else
    assign retry_ok = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = tx_valid ? INHIBIT : IDLE;
            INHIBIT: nxt = inh_cnt == INH_LAST ? RTS : INHIBIT;
            RTS:     nxt = fall ? SHIFT : RTS;
            SHIFT:   nxt = fall && n == 4'd9 ? ACK : SHIFT;
            ACK:     nxt = !fall ? ACK : data_f ? ERR : WAITREL;
            WAITREL: nxt = clk_f && data_f ? IDLE : WAITREL;
            default: nxt = IDLE;
        endcase
        if (timeout && nxt == state) nxt = ERR;
        fail    = nxt == ERR;
        state_n = fail && retry_ok ? INHIBIT : nxt;
    end

    // n counts device falls: fall 1 (in RTS) puts d0 out, falls 2..9 the rest and parity, fall 10 releases for stop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inh_cnt   <= '0;
            wd_cnt    <= '0;
            n         <= '0;
            shift     <= '0;
            frm       <= '0;
            data_oe_q <= 1'b0;
        end else begin
            inh_cnt <= state == INHIBIT && inh_cnt != INH_MAX ? inh_cnt + 1'b1 : '0;
            wd_cnt  <= !watch || fall ? '0 : wd_cnt == WD_MAX ? wd_cnt : wd_cnt + 1'b1;
            if (state == IDLE && tx_valid) frm <= {~^tx_data, tx_data};
            if (state_n == INHIBIT && state != INHIBIT) begin
                shift     <= state == IDLE ? {~^tx_data, tx_data} : frm;
                n         <= '0;
                data_oe_q <= 1'b0;
            end else if (state == INHIBIT && state_n == RTS) begin
                data_oe_q <= 1'b1;
            end else if (state_n == ERR || state_n == IDLE) begin
                data_oe_q <= 1'b0;
            end else if (fall && (state == RTS || state == SHIFT)) begin
                n         <= n + 1'b1;
                data_oe_q <= n != 4'd9 && !shift[0];
                shift     <= shift >> 1;
            end
        end
    end

    assign tx_ready    = state == IDLE;
    assign rx_inhibit  = state != IDLE;
    assign tx_done     = state == WAITREL && state_n == IDLE;
    assign tx_err      = state == ERR;
    assign ps2_clk_oe  = state == INHIBIT;
    // Start bit appears on the final inhibit cycle, before the registered enable catches up.
    assign ps2_data_oe = data_oe_q | (state == INHIBIT && inh_cnt == INH_LAST);
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed scoreboard bench for ps2_host_tx with a PS/2 device model
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin failures++; $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); end end

module tb_ps2_host_tx;
    localparam int INH = 5000;
    localparam int TO  = 3000;
    localparam int HP  = 20;
`ifdef PS2_TX_RESEND_EN
    localparam int TRIES = 3;
`else
    localparam int TRIES = 1;
`endif

    logic       clk = 1'b0, reset = 1'b1, tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_done, tx_err, rx_inhibit, ps2_clk_oe, ps2_data_oe;
    logic       ps2_clk_i, ps2_data_i;
    logic       dev_clk = 1'b1, dev_data = 1'b1, glitch = 1'b0, err_oe = 1'b1;
    int         checks = 0, failures = 0, n_done = 0, n_err = 0, n_both = 0;
    logic       sb[$];

    assign ps2_clk_i  = ~ps2_clk_oe & dev_clk & ~glitch;
    assign ps2_data_i = ~ps2_data_oe & dev_data;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(4)) dut (
        .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err), .rx_inhibit(rx_inhibit),
        .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done) n_done++;
        if (tx_err) begin
            n_err++;
            err_oe = ps2_clk_oe | ps2_data_oe;
        end
        if (tx_done && tx_err) n_both++;
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] d);
        for (int i = 0; i < 8; i++) sb.push_back(d[i]);
        sb.push_back(~^d);
        sb.push_back(1'b1);
    endtask

    task automatic device(input int edges, input logic ack, input int gl);
        int   w = 0;
        logic exp;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && w < 4 * INH) begin
            tick(1);
            w++;
        end
        `CHK("rts_seen", w < 4 * INH, 1'b1)
        `CHK("start_bit", ps2_data_i, 1'b0)
        for (int e = 1; e <= edges; e++) begin
            if (e == gl) begin
                tick(8);
                glitch = 1'b1;
                tick(3);
                glitch = 1'b0;
                tick(HP - 11);
            end else tick(HP);
            dev_clk = 1'b0;
            tick(HP);
            if (e <= 10 && sb.size() > 0) begin
                exp = sb.pop_front();
                `CHK("frame_bit", ps2_data_i, exp)
            end
            if (e == 10 && ack) dev_data = 1'b0;
            dev_clk = 1'b1;
            if (e == 11) dev_data = 1'b1;
        end
    endtask

    task automatic wait_outcome(input int limit, input int d0, input int e0, output int w);
        w = 0;
        while (n_done == d0 && n_err == e0 && w < limit) begin
            tick(1);
            w++;
        end
        tick(2);
    endtask

    initial begin
        int d0, e0, w, first;
        tick(3);
        `CHK("rst_ready", tx_ready, 1'b1)
        `CHK("rst_inhibit", rx_inhibit, 1'b0)
        `CHK("rst_clk_oe", ps2_clk_oe, 1'b0)
        `CHK("rst_data_oe", ps2_data_oe, 1'b0)
        `CHK("rst_done", tx_done, 1'b0)
        `CHK("rst_err", tx_err, 1'b0)
        reset = 1'b0;
        tick(2);

        d0 = n_done; e0 = n_err;
        send(8'hED);
        push_exp(8'hED);
        `CHK("busy_ready", tx_ready, 1'b0)
        `CHK("busy_inhibit", rx_inhibit, 1'b1)
        device(11, 1'b1, 0);
        wait_outcome(500, d0, e0, w);
        `CHK("ed_done", n_done - d0, 1)
        `CHK("ed_err", n_err - e0, 0)
        `CHK("ed_ready", tx_ready, 1'b1)

        d0 = n_done; e0 = n_err;
        send(8'hF4);
        push_exp(8'hF4);
        w = 0; first = -1;
        while (ps2_clk_oe === 1'b1 && w < 2 * INH) begin
            if (ps2_data_oe === 1'b1 && first < 0) first = w;
            w++;
            tick(1);
        end
        `CHK("inhibit_len", w, INH)
        `CHK("start_rise", first, INH - 1)
        device(11, 1'b1, 0);
        wait_outcome(500, d0, e0, w);
        `CHK("f4_done", n_done - d0, 1)
        `CHK("f4_err", n_err - e0, 0)

        d0 = n_done; e0 = n_err;
        send(8'hAA);
        for (int t = 0; t < TRIES; t++) begin
            push_exp(8'hAA);
            device(11, 1'b0, 0);
            if (t < TRIES - 1) `CHK("retry_inhibit", rx_inhibit, 1'b1)
        end
        wait_outcome(500, d0, e0, w);
        `CHK("nack_err", n_err - e0, 1)
        `CHK("nack_done", n_done - d0, 0)
        `CHK("nack_oe", err_oe, 1'b0)

        d0 = n_done; e0 = n_err;
        send(8'h12);
        for (int t = 0; t < TRIES; t++) begin
            push_exp(8'h12);
            device(4, 1'b1, 0);
            sb.delete();
        end
        wait_outcome(TO + 500, d0, e0, w);
        `CHK("to_err", n_err - e0, 1)
        `CHK("to_done", n_done - d0, 0)
        `CHK("to_oe", err_oe, 1'b0)
        `CHK("to_delay", w >= TO - 40 && w <= TO + 40, 1'b1)

        d0 = n_done; e0 = n_err;
        send(8'hED);
        push_exp(8'hED);
        device(5, 1'b1, 0);
        sb.delete();
        `CHK("pre_rst_data_oe", ps2_data_oe, 1'b1)
        #2 reset = 1'b1;
        #1;
        `CHK("async_clk_oe", ps2_clk_oe, 1'b0)
        `CHK("async_data_oe", ps2_data_oe, 1'b0)
        tick(2);
        reset = 1'b0;
        tick(1);
        `CHK("post_rst_ready", tx_ready, 1'b1)
        tick(200);
        `CHK("post_rst_done", n_done - d0, 0)
        `CHK("post_rst_err", n_err - e0, 0)

        d0 = n_done; e0 = n_err;
        send(8'hED);
        push_exp(8'hED);
        tick(100);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        device(11, 1'b1, 3);
        wait_outcome(500, d0, e0, w);
        `CHK("busy_done", n_done - d0, 1)
        `CHK("busy_err", n_err - e0, 0)
        tick(300);
        `CHK("no_queue_ready", tx_ready, 1'b1)
        `CHK("no_queue_clk_oe", ps2_clk_oe, 1'b0)
        `CHK("no_queue_done", n_done - d0, 1)

        `CHK("done_err_exclusive", n_both, 0)
        `CHK("scoreboard_empty", sb.size(), 0)
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
